stoch_bitstream_decoder: RTL and testbench
==========================================

# stoch_bitstream_decoder

Converts stochastic bitstreams back to binary values. It counts the ones on each of NCH parallel stochastic lines over a programmable window of 2^k valid samples, then presents normalised WIDTH-bit results through a VALID/ACK handshake. It sits at the output of the stochastic datapath, after neuron and synapse logic, and is the inverse of the LFSR-plus-comparator number generators at the input.

## Interface
- WIDTH, 8: result width per channel and maximum window exponent.
- NCH, 4: number of parallel bitstream channels.
- CLK  in  1  rising-edge clock.
- RESET  in  1  reset, asynchronous, active-high.
- EN  in  1  sample strobe; one bit per channel is taken on each CLK edge where EN=1 (the same strobe that advances the generator LFSRs).
- START  in  1  request to begin a conversion window.
- WIN_LOG2  in  4  window exponent k, latched at start.
- BITS  in  NCH  stochastic bit per channel.
- ACK  in  1  consumer has taken RESULT.
- BUSY  out  1  high while a window is accumulating.
- VALID  out  1  high while RESULT holds a completed conversion.
- RESULT  out  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].

## Operation
- FSM states are IDLE, ACCUM and DONE; RESET forces IDLE.
- **IDLE:**
  - START=1 moves to ACCUM on the next edge.
  - On that edge, clear all channel counters and the sample counter, and latch k_eff = clamp(WIN_LOG2, 1, WIDTH). WIN_LOG2=0 gives k_eff=1; WIN_LOG2>WIDTH gives k_eff=WIDTH.
- **ACCUM:**
  - On each edge with EN=1: sample counter +1, and channel counter i += BITS[i].
  - EN=0 freezes all counters.
  - START is ignored.
  - When the sample being taken is sample number 2^k_eff, the same edge loads RESULT and moves to DONE.
- **DONE:**
  - RESULT is held stable and BITS/EN are ignored.
  - ACK=1 leaves DONE on the next edge.
  - ACK=1 with START=1 goes directly to ACCUM, with the same clear and latch as IDLE→ACCUM.
  - ACK=1 with START=0 goes to IDLE.
  - START without ACK is ignored.
- **Counters:**
  - Channel counters are WIDTH+1 bits, range 0..2^WIDTH.
  - The sample counter is WIDTH+1 bits.
- **Result arithmetic:**
  - RESULT_i = cnt_i << (WIDTH − k_eff), computed at WIDTH+1 bits.
  - If the value is ≥ 2^WIDTH, saturate to 2^WIDTH−1. An all-ones stream therefore reads 255 for WIDTH=8, not 0.
  - The final sample's bit is included in the loaded RESULT.
- **Outputs:**
  - BUSY = (state==ACCUM).
  - VALID = (state==DONE).
  - Both are registered state decodes with no combinational path from inputs.
- **RESET mid-operation:** immediate return to IDLE. Counters, RESULT, BUSY and VALID are cleared asynchronously and the partial window is discarded.

## Timing
- Reset values: BUSY=0, VALID=0, RESULT=0, all counters 0, state IDLE.
- START accepted at edge t0: BUSY=1 after t0. The first sample is taken at the first EN=1 edge after t0; EN at t0 itself is not sampled.
- With EN held at 1, VALID rises after edge t0+2^k_eff and BUSY falls at the same edge. Latency from the START edge is 2^k_eff cycles; with EN gaps, it is the number of EN-qualified edges.
- ACK sampled at edge ta in DONE: VALID=0 after ta. RESULT retains its value until the next window completes.
- Throughput with back-to-back ACK+START is 2^k_eff+1 cycles per conversion, because the DONE state lasts at least one cycle.
- No combinational input→output paths; all outputs change only on CLK edges or RESET.

## Test plan
- **Reset:** assert RESET asynchronously mid-cycle with no clock → BUSY=0, VALID=0, RESULT=0 immediately; release and idle 10 cycles → outputs unchanged.
- **Full window:** WIN_LOG2=8, EN=1, BITS[0]=1 constant, BITS[1]=0, BITS[2] alternating 1/0, BITS[3] with 64 ones in 256 → VALID after edge t0+256; RESULT = {64, 128, 0, 255}, where ch0 saturates from 256 to 255.
- **Gapped strobe, short window:** WIN_LOG2=4, EN toggling 1/0, ch0 with 4 ones among the 16 samples → VALID after edge t0+31; RESULT ch0 = 4<<4 = 64.
- **Hold:** after VALID, keep ACK=0 for 100 cycles with random BITS/EN and START pulses → RESULT and VALID unchanged, no new window. Then ACK=1 with START=1 in the same cycle → VALID=0 and BUSY=1 after that edge.
- **Clamp:** WIN_LOG2=0 → window of 2 samples, RESULT ch0 = ones<<7 (0, 128 or 255). WIN_LOG2=12 → 256-sample window, identical to WIN_LOG2=8.
- **Reset mid-window:** START, 50 samples, then RESET → BUSY=0 and RESULT=0 at once. A subsequent START and a full window produce a result uncontaminated by the aborted partial counts.

Source files
------------

// File: rtl/stoch_bitstream_decoder_if.sv
// Handshake/data bundle between the stochastic datapath and the bitstream decoder.
interface stoch_bitstream_decoder_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
);
    logic                 EN;
    logic                 START;
    logic [3:0]           WIN_LOG2;
    logic [NCH-1:0]       BITS;
    logic                 ACK;
    logic                 BUSY;
    logic                 VALID;
    logic [NCH*WIDTH-1:0] RESULT;

    modport master (
        output EN, START, WIN_LOG2, BITS, ACK,
        input  BUSY, VALID, RESULT
    );

    modport slave (
        input  EN, START, WIN_LOG2, BITS, ACK,
        output BUSY, VALID, RESULT
    );
endinterface

// File: rtl/stoch_bitstream_decoder.sv
// Counts ones on NCH stochastic lines over 2^k EN-qualified samples and
// presents saturated, normalised WIDTH-bit results behind a VALID/ACK handshake.
module stoch_bitstream_decoder #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
) (
    input  logic                      CLK,
    input  logic                      RESET,
    stoch_bitstream_decoder_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]                  state_q, state_d;
    logic [3:0]                  k_q, k_d;
    logic [WIDTH:0]              smp_q, smp_d;
    logic [NCH-1:0][WIDTH:0]     cnt_q, cnt_d;
    logic [NCH-1:0][WIDTH-1:0]   res_q, res_d;

    logic [3:0]     k_start;
    logic [3:0]     shamt;
    logic [WIDTH:0] win_len;
    logic [WIDTH:0] scaled;
    logic           start_win;

    // k is clamped once at window start so mid-window WIN_LOG2 changes are harmless.
    always_comb begin
        if (bus.WIN_LOG2 == 4'd0)
            k_start = 4'd1;
        else if (int'(bus.WIN_LOG2) > WIDTH)
            k_start = 4'(WIDTH);
        else
            k_start = bus.WIN_LOG2;
    end

    assign win_len = {{WIDTH{1'b0}}, 1'b1} << k_q;
    assign shamt   = 4'(WIDTH) - k_q;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        smp_d     = smp_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        scaled    = '0;
        start_win = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.START)
                    start_win = 1'b1;
            end
            S_ACCUM: begin
                if (bus.EN) begin
                    smp_d = smp_q + 1'b1;
                    for (int unsigned i = 0; i < NCH; i++)
                        cnt_d[i] = cnt_q[i] + {{WIDTH{1'b0}}, bus.BITS[i]};
                    // Final sample: its bit is already folded into cnt_d.
                    if (smp_d == win_len) begin
                        for (int unsigned i = 0; i < NCH; i++) begin
                            scaled = cnt_d[i] << shamt;
                            res_d[i] = scaled[WIDTH] ? '1 : scaled[WIDTH-1:0];
                        end
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (bus.ACK) begin
                    if (bus.START)
                        start_win = 1'b1;
                    else
                        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start_win) begin
            state_d = S_ACCUM;
            smp_d   = '0;
            cnt_d   = '0;
            k_d     = k_start;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            k_q     <= 4'd1;
            smp_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            smp_q   <= smp_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign bus.BUSY   = (state_q == S_ACCUM);
    assign bus.VALID  = (state_q == S_DONE);
    assign bus.RESULT = res_q;
endmodule

// File: tb/tb_stoch_bitstream_decoder.sv
// Bench for stoch_bitstream_decoder: table of conversions checked against a
// ones-counting reference model, plus hold, reset and handshake sequences.
module tb_stoch_bitstream_decoder;
    localparam int W  = 8;
    localparam int NC = 4;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    stoch_bitstream_decoder_if #(.WIDTH(W), .NCH(NC)) bus ();

    stoch_bitstream_decoder #(.WIDTH(W), .NCH(NC)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    typedef struct {
        string           nm;
        logic [3:0]      wl;
        int              bmode;   // 0: fixed mix, 1: random, 2: short-window mix
        int              emode;   // 0: EN=1, 1: toggling, 2: random
        bit              has_exp;
        logic [NC*W-1:0] exp_res;
        int              exp_lat; // -1: not checked
    } vec_t;

    vec_t tbl[10];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic int clamp_k(input logic [3:0] wl);
        if (wl == 0) return 1;
        if (int'(wl) > W) return W;
        return int'(wl);
    endfunction

    // Expected value: fraction of ones scaled to 2^W, capped at full scale.
    function automatic logic [W-1:0] ref_res(input int ones, input int k);
        int v;
        v = ones * (1 << (W - k));
        if (v >= (1 << W)) return W'((1 << W) - 1);
        return W'(v);
    endfunction

    function automatic logic [NC-1:0] gen_bits(input int mode, input int s);
        logic [NC-1:0] b;
        case (mode)
            0: begin
                b[0] = 1'b1;
                b[1] = 1'b0;
                b[2] = (s % 2 == 0);
                b[3] = (s % 4 == 0);
            end
            2: begin
                b[0] = (s < 4);
                b[1] = 1'b1;
                b[2] = 1'b0;
                b[3] = (s % 2 == 0);
            end
            default: b = NC'($urandom);
        endcase
        return b;
    endfunction

    function automatic logic gen_en(input int mode, input int idx);
        case (mode)
            0:       return 1'b1;
            1:       return (idx % 2 == 0);
            default: return ($urandom_range(0, 3) != 0);
        endcase
    endfunction

    task automatic run_conv(input vec_t v);
        int k, n, taken, cyc, bad;
        int ones[NC];
        logic [NC-1:0]   b;
        logic            e;
        logic [NC*W-1:0] exp_model;
        k = clamp_k(v.wl);
        n = 1 << k;
        taken = 0; cyc = 0; bad = 0;
        for (int i = 0; i < NC; i++) ones[i] = 0;

        // EN/BITS on the START edge must not be counted.
        bus.START = 1'b1; bus.ACK = 1'b1; bus.WIN_LOG2 = v.wl;
        bus.EN = 1'b1; bus.BITS = '1;
        step();
        bus.START = 1'b0; bus.ACK = 1'b0;
        bus.WIN_LOG2 = 4'($urandom_range(0, 15));
        chk({v.nm, "/start_flags"}, 64'({bus.BUSY, bus.VALID}), 64'(2'b10));

        while (taken < n && cyc < 8000) begin
            e = gen_en(v.emode, cyc);
            b = gen_bits(v.bmode, taken);
            bus.EN = e; bus.BITS = b;
            step();
            cyc++;
            if (e) begin
                taken++;
                for (int i = 0; i < NC; i++) ones[i] += int'(b[i]);
            end
            if (taken < n && (bus.VALID !== 1'b0 || bus.BUSY !== 1'b1)) bad++;
        end
        bus.EN = 1'b0;

        chk({v.nm, "/busy_during_window"}, 64'(bad), 64'd0);
        chk({v.nm, "/done_flags"}, 64'({bus.BUSY, bus.VALID}), 64'(2'b01));
        if (v.exp_lat >= 0)
            chk({v.nm, "/latency"}, 64'(cyc), 64'(v.exp_lat));
        for (int i = 0; i < NC; i++) exp_model[i*W +: W] = ref_res(ones[i], k);
        chk({v.nm, "/result_model"}, 64'(bus.RESULT), 64'(exp_model));
        if (v.has_exp)
            chk({v.nm, "/result_table"}, 64'(bus.RESULT), 64'(v.exp_res));
    endtask

    initial begin
        logic [NC*W-1:0] saved;
        int bad;
        logic [3:0] rwl;

        tbl[0] = '{"full_w8",   4'd8,  0, 0, 1'b1, {8'd64, 8'd128, 8'd0, 8'd255}, 256};
        tbl[1] = '{"gapped_w4", 4'd4,  2, 1, 1'b1, {8'd128, 8'd0, 8'd255, 8'd64}, 31};
        tbl[2] = '{"clamp_w0",  4'd0,  0, 0, 1'b1, {8'd128, 8'd128, 8'd0, 8'd255}, 2};
        tbl[3] = '{"clamp_w12", 4'd12, 0, 0, 1'b1, {8'd64, 8'd128, 8'd0, 8'd255}, 256};
        tbl[4] = '{"mid_w5",    4'd5,  0, 0, 1'b1, {8'd64, 8'd128, 8'd0, 8'd255}, 32};
        for (int i = 5; i < 10; i++) begin
            rwl = 4'($urandom_range(0, 15));
            if (i == 5)
                tbl[i] = '{$sformatf("rand%0d", i), rwl, 1, 0, 1'b0, '0, 1 << clamp_k(rwl)};
            else
                tbl[i] = '{$sformatf("rand%0d", i), rwl, 1, 2, 1'b0, '0, -1};
        end

        bus.EN = 1'b0; bus.START = 1'b0; bus.ACK = 1'b0;
        bus.WIN_LOG2 = 4'd0; bus.BITS = '0;

        // Asynchronous reset between clock edges.
        #3 RESET = 1'b1;
        #1 chk("reset_async", 64'({bus.BUSY, bus.VALID, bus.RESULT}), 64'd0);
        #8 RESET = 1'b0;
        repeat (10) step();
        chk("reset_idle", 64'({bus.BUSY, bus.VALID, bus.RESULT}), 64'd0);

        for (int i = 0; i < 10; i++) run_conv(tbl[i]);

        // Hold in DONE: no ACK, noisy inputs and START pulses.
        saved = bus.RESULT;
        bad = 0;
        repeat (100) begin
            bus.ACK = 1'b0;
            bus.START = 1'($urandom_range(0, 1));
            bus.EN = 1'($urandom_range(0, 1));
            bus.BITS = NC'($urandom);
            step();
            if (bus.VALID !== 1'b1 || bus.BUSY !== 1'b0 || bus.RESULT !== saved) bad++;
        end
        chk("hold_done", 64'(bad), 64'd0);

        bus.ACK = 1'b1; bus.START = 1'b1; bus.WIN_LOG2 = 4'd8;
        step();
        bus.ACK = 1'b0; bus.START = 1'b0;
        chk("ack_start_flags", 64'({bus.BUSY, bus.VALID}), 64'(2'b10));

        // Partial window then asynchronous abort.
        bus.EN = 1'b1; bus.BITS = '1;
        repeat (50) step();
        chk("result_retained", 64'(bus.RESULT), 64'(saved));
        #3 RESET = 1'b1;
        #1 chk("reset_mid_window", 64'({bus.BUSY, bus.VALID, bus.RESULT}), 64'd0);
        #2 RESET = 1'b0;
        bus.EN = 1'b0;
        step();
        chk("post_reset_idle", 64'({bus.BUSY, bus.VALID}), 64'd0);

        tbl[0].nm = "after_abort";
        run_conv(tbl[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
